// File: rtl/wdt_pkg.sv
// Shared types and constants for the watchdog / software-reset requester.
package wdt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_BARK = 2'd2,
        ST_REQ  = 2'd3
    } wdt_state_e;

    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_LOAD  = 2'd1;
    localparam logic [1:0] REG_CMD   = 2'd2;
    localparam logic [1:0] REG_COUNT = 2'd3;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_IRQ_EN   = 1;
    localparam int CTRL_RST_EN   = 2;
    localparam int CTRL_BARK     = 8;
    localparam int CTRL_STATE_LO = 9;

    localparam logic [31:0] KICK_KEY_DEF = 32'h5A5A_0F0F;
    localparam logic [31:0] SRST_KEY_DEF = 32'hA5A5_F0F0;

    // CTRL readback: control bits plus bark flag and FSM state.
    function automatic logic [31:0] ctrl_word(input logic [2:0] ctrl,
                                              input logic bark,
                                              input wdt_state_e st);
        logic [31:0] w;
        w = '0;
        w[2:0] = ctrl;
        w[CTRL_BARK] = bark;
        w[CTRL_STATE_LO +: 2] = st;
        return w;
    endfunction

endpackage

// File: rtl/wdt_rst_req_if.sv
// Peripheral register bus plus the watchdog's interrupt and reset-request outputs.
interface wdt_rst_req_if;
    logic        wr_en;
    logic        rd_en;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        wdt_irq;
    logic        soft_rst_en;

    modport master (
        output wr_en, rd_en, addr, wdata,
        input  rdata, wdt_irq, soft_rst_en
    );

    modport slave (
        input  wr_en, rd_en, addr, wdata,
        output rdata, wdt_irq, soft_rst_en
    );
endinterface

// File: rtl/wdt_pulse_gen.sv
// Fixed-length pulse generator: a trigger starts a PULSE_LEN-cycle high level,
// after which done stays set until reset.
module wdt_pulse_gen #(
    parameter int PULSE_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trig_i,
    output logic pulse_o,
    output logic done_o
);
    localparam int CW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(PULSE_LEN - 1);

    logic [CW-1:0] cnt_q;
    logic          pulse_q;
    logic          done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (pulse_q) begin
            if (cnt_q == LAST) begin
                pulse_q <= 1'b0;
                done_q  <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end else if (trig_i) begin
            pulse_q <= 1'b1;
            cnt_q   <= '0;
        end
    end

    assign pulse_o = pulse_q;
    assign done_o  = done_q;
endmodule

// File: rtl/wdt_rst_req.sv
// Watchdog with bark interrupt and bite reset request, plus keyed software reset,
// driving the reset controller's soft_rst_en input.
module wdt_rst_req
    import wdt_pkg::*;
#(
    parameter int          CNT_W     = 32,
    parameter int          PULSE_LEN = 4,
    parameter logic [31:0] KICK_KEY  = KICK_KEY_DEF,
    parameter logic [31:0] SRST_KEY  = SRST_KEY_DEF
) (
    input logic           clk,
    input logic           rst_n,
    wdt_rst_req_if.slave  bus
);
    logic [2:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] load_q, load_d;
    logic [CNT_W-1:0] cnt_q;
    wdt_state_e       state_q;
    logic             bark_q;
    logic             irq_q;
    logic [31:0]      rdata_q;

    logic [1:0] idx;
    logic       wr_ctrl, wr_load, wr_cmd;
    logic       kick, srst_wr, en_rise, en_clear, expired, active;
    logic       req_go;
    logic       pulse, pulse_done;
    logic       unused_addr;

    assign idx         = bus.addr[3:2];
    assign unused_addr = ^bus.addr[1:0];
    assign wr_ctrl     = bus.wr_en && (idx == REG_CTRL);
    assign wr_load     = bus.wr_en && (idx == REG_LOAD);
    assign wr_cmd      = bus.wr_en && (idx == REG_CMD);
    assign kick        = wr_cmd && (bus.wdata == KICK_KEY);
    assign srst_wr     = wr_cmd && (bus.wdata == SRST_KEY);
    assign en_rise     = wr_ctrl && bus.wdata[CTRL_EN] && !ctrl_q[CTRL_EN];
    assign en_clear    = wr_ctrl && !bus.wdata[CTRL_EN];
    assign expired     = (cnt_q == '0);
    assign active      = (state_q == ST_RUN) || (state_q == ST_BARK);

    always_comb begin
        ctrl_d = ctrl_q;
        load_d = load_q;
        if (wr_ctrl) ctrl_d = bus.wdata[2:0];
        if (wr_load) load_d = bus.wdata[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
            load_q <= '1;
        end else begin
            ctrl_q <= ctrl_d;
            load_q <= load_d;
        end
    end

    // Entry into REQ is decoded here so the pulse starts on the same edge as the state change.
    always_comb begin
        req_go = srst_wr;
        if (active && !en_clear && !kick && expired && ctrl_q[CTRL_RST_EN] &&
            (state_q == ST_BARK || !ctrl_q[CTRL_IRQ_EN])) begin
            req_go = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '1;
            bark_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else if (srst_wr) begin
            state_q <= ST_REQ;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (kick) begin
                        cnt_q  <= load_q;
                        bark_q <= 1'b0;
                        irq_q  <= 1'b0;
                    end
                    if (en_rise) begin
                        cnt_q   <= load_q;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN, ST_BARK: begin
                    if (en_clear) begin
                        state_q <= ST_IDLE;
                        irq_q   <= 1'b0;
                    end else if (kick) begin
                        state_q <= ST_RUN;
                        cnt_q   <= load_q;
                        bark_q  <= 1'b0;
                        irq_q   <= 1'b0;
                    end else if (!expired) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (state_q == ST_RUN) begin
                        if (ctrl_q[CTRL_IRQ_EN]) begin
                            state_q <= ST_BARK;
                            bark_q  <= 1'b1;
                            irq_q   <= 1'b1;
                            cnt_q   <= load_q;
                        end else if (ctrl_q[CTRL_RST_EN]) begin
                            state_q <= ST_REQ;
                        end else begin
                            bark_q <= 1'b1;
                            cnt_q  <= load_q;
                        end
                    end else if (ctrl_q[CTRL_RST_EN]) begin
                        state_q <= ST_REQ;
                    end
                end
                default: ;
            endcase
        end
    end

    // One pulse per reset cycle: later SRST writes while in REQ are absorbed.
    wdt_pulse_gen #(.PULSE_LEN(PULSE_LEN)) u_pulse (
        .clk     (clk),
        .rst_n   (rst_n),
        .trig_i  (req_go && !pulse && !pulse_done),
        .pulse_o (pulse),
        .done_o  (pulse_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (bus.rd_en && !bus.wr_en) begin
            unique case (idx)
                REG_CTRL:  rdata_q <= ctrl_word(ctrl_q, bark_q, state_q);
                REG_LOAD:  rdata_q <= 32'(load_q);
                REG_CMD:   rdata_q <= '0;
                REG_COUNT: rdata_q <= 32'(cnt_q);
            endcase
        end else begin
            rdata_q <= '0;
        end
    end

    assign bus.rdata       = rdata_q;
    assign bus.wdt_irq     = irq_q;
    assign bus.soft_rst_en = pulse;
endmodule

// File: tb/tb_wdt_rst_req.sv
// Scoreboard bench for wdt_rst_req: expected reads and output edges are queued by
// the stimulus and consumed by an independent monitor.
module tb_wdt_rst_req;
    localparam logic [3:0]  A_CTRL  = 4'h0;
    localparam logic [3:0]  A_LOAD  = 4'h4;
    localparam logic [3:0]  A_CMD   = 4'h8;
    localparam logic [3:0]  A_COUNT = 4'hC;
    localparam logic [31:0] KICK    = 32'h5A5A_0F0F;
    localparam logic [31:0] SRST    = 32'hA5A5_F0F0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } rd_t;

    typedef struct {
        string name;
        int    sig;    // 0 = wdt_irq, 1 = soft_rst_en
        logic  val;
        int    cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic rd_vld = 1'b0;
    logic mon_en = 1'b0;
    logic irq_prev = 1'b0;
    logic srst_prev = 1'b0;
    rd_t  rd_q[$];
    ev_t  ev_q[$];

    wdt_rst_req_if bus ();

    wdt_rst_req dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rd_vld <= bus.rd_en;
    end

    task automatic check_evt(input int sig, input logic val);
        ev_t e;
        checks++;
        if (ev_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_edge: sig=%0d val=%0b cyc=%0d, required no edge", sig, val, cyc);
        end else begin
            e = ev_q.pop_front();
            if (e.sig != sig || e.val !== val || e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: got sig=%0d val=%0b cyc=%0d, required sig=%0d val=%0b cyc=%0d",
                         e.name, sig, val, cyc, e.sig, e.val, e.cyc);
            end else begin
                $display("chk %s: sig=%0d val=%0b cyc=%0d ok", e.name, sig, val, cyc);
            end
        end
    endtask

    // Monitor: consumes registered read data and output edges.
    initial begin
        rd_t r;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rd_vld) begin
                    checks++;
                    if (rd_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_read: rdata=0x%08h with no expectation", bus.rdata);
                    end else begin
                        r = rd_q.pop_front();
                        if (bus.rdata !== r.exp) begin
                            errors++;
                            $display("FAIL %s: rdata=0x%08h required 0x%08h", r.name, bus.rdata, r.exp);
                        end else begin
                            $display("chk %s: rdata=0x%08h ok", r.name, bus.rdata);
                        end
                    end
                end
                if (bus.wdt_irq !== irq_prev) check_evt(0, bus.wdt_irq);
                if (bus.soft_rst_en !== srst_prev) check_evt(1, bus.soft_rst_en);
                irq_prev  = bus.wdt_irq;
                srst_prev = bus.soft_rst_en;
            end
        end
    end

    task automatic push_ev(input string name, input int sig, input logic val, input int c);
        ev_t e;
        e.name = name; e.sig = sig; e.val = val; e.cyc = c;
        ev_q.push_back(e);
    endtask

    // All bus tasks start and end 1 time unit after a rising edge.
    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d, output int e);
        bus.addr = a; bus.wdata = d; bus.wr_en = 1'b1;
        @(posedge clk); #1;
        e = cyc;
        bus.wr_en = 1'b0;
    endtask

    task automatic bus_rd(input logic [3:0] a, input logic [31:0] exp, input string name);
        rd_t r;
        r.name = name; r.exp = exp;
        rd_q.push_back(r);
        bus.addr = a; bus.rd_en = 1'b1;
        @(posedge clk); #1;
        bus.rd_en = 1'b0;
    endtask

    task automatic bus_wr_rd(input logic [3:0] a, input logic [31:0] d, input string name);
        rd_t r;
        r.name = name; r.exp = 32'h0;
        rd_q.push_back(r);
        bus.addr = a; bus.wdata = d; bus.wr_en = 1'b1; bus.rd_en = 1'b1;
        @(posedge clk); #1;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (ev_q.size() != 0) begin
            errors++;
            $display("FAIL %s: pending edges=%0d required 0 (next %s)", name, ev_q.size(), ev_q[0].name);
            ev_q.delete();
        end else begin
            $display("chk %s: pending edges=0 ok", name);
        end
    endtask

    // Asynchronous reset dropped mid-cycle; outputs that were high must fall at once.
    task automatic do_reset(input bit irq_hi, input bit srst_hi);
        #1;
        if (irq_hi)  push_ev("rst_irq_fall", 0, 1'b0, cyc);
        if (srst_hi) push_ev("rst_srst_fall", 1, 1'b0, cyc);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_cyc(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        int e;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = '0; bus.wdata = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_cyc(1);
        mon_en = 1'b1;

        // Reset state
        bus_rd(A_CTRL,  32'h0000_0000, "rst_ctrl");
        bus_rd(A_LOAD,  32'hFFFF_FFFF, "rst_load");
        bus_rd(A_COUNT, 32'hFFFF_FFFF, "rst_count");
        bus_rd(A_CMD,   32'h0000_0000, "rst_cmd");

        // Bark then bite
        bus_wr(A_LOAD, 32'd10, e);
        bus_wr(A_CTRL, 32'h7, e);
        push_ev("bite_irq_rise",  0, 1'b1, e + 11);
        push_ev("bite_srst_rise", 1, 1'b1, e + 22);
        push_ev("bite_srst_fall", 1, 1'b0, e + 26);
        bus_rd(A_COUNT, 32'd10, "bite_count_start");
        wait_cyc(28);
        bus_rd(A_CTRL, 32'h0000_0707, "bite_ctrl_req");
        bus_wr(A_CMD, KICK, e);
        bus_rd(A_CTRL, 32'h0000_0707, "req_ignores_kick");
        bus_rd(A_COUNT, 32'h0, "req_count");
        check_drained("bite_edges");
        do_reset(1'b1, 1'b0);
        bus_rd(A_COUNT, 32'hFFFF_FFFF, "async_rst_count");
        bus_rd(A_CTRL,  32'h0, "async_rst_ctrl");

        // Periodic kick keeps everything quiet
        bus_wr(A_LOAD, 32'd10, e);
        bus_wr(A_CTRL, 32'h7, e);
        for (int i = 0; i < 13; i++) begin
            bus_wr(A_CMD, KICK, e);
            wait_cyc(7);
        end
        bus_wr(A_CMD, KICK, e);
        bus_rd(A_COUNT, 32'd10, "kick_count_reload");
        bus_wr(A_CTRL, 32'h0, e);
        bus_rd(A_CTRL, 32'h0, "kick_ctrl_idle");
        check_drained("kick_no_edges");

        // Kick in the same cycle as expiry
        bus_wr(A_LOAD, 32'd3, e);
        bus_wr(A_CTRL, 32'h7, e);
        wait_cyc(3);
        bus_wr(A_CMD, KICK, e);
        bus_rd(A_COUNT, 32'd3, "collide_count");
        bus_rd(A_CTRL, 32'h0000_0207, "collide_ctrl_run");
        bus_wr(A_CTRL, 32'h0, e);
        bus_rd(A_CTRL, 32'h0, "collide_ctrl_idle");

        // Software reset
        bus_wr(A_CMD, 32'h0000_1234, e);
        wait_cyc(3);
        bus_rd(A_CTRL, 32'h0, "bad_key_ignored");
        bus_wr(A_CMD, SRST, e);
        push_ev("srst_rise", 1, 1'b1, e);
        push_ev("srst_fall", 1, 1'b0, e + 4);
        wait_cyc(7);
        bus_rd(A_CTRL, 32'h0000_0600, "srst_ctrl_req");
        bus_rd(A_CMD, 32'h0, "cmd_reads_zero");
        check_drained("srst_edges");
        do_reset(1'b0, 1'b0);
        bus_wr(A_CMD, SRST, e);
        push_ev("midpulse_srst_rise", 1, 1'b1, e);
        wait_cyc(1);
        do_reset(1'b0, 1'b1);
        bus_rd(A_COUNT, 32'hFFFF_FFFF, "midpulse_rst_count");
        check_drained("midpulse_edges");

        // Bark without reset: counter stalls at zero, kick clears the interrupt
        bus_wr(A_LOAD, 32'd5, e);
        bus_wr(A_CTRL, 32'h3, e);
        push_ev("norst_irq_rise", 0, 1'b1, e + 6);
        wait_cyc(14);
        bus_rd(A_COUNT, 32'h0, "norst_count_stall");
        bus_rd(A_CTRL, 32'h0000_0503, "norst_ctrl_bark");
        push_ev("norst_kick_irq_fall", 0, 1'b0, cyc + 1);
        bus_wr(A_CMD, KICK, e);
        bus_rd(A_COUNT, 32'd5, "norst_kick_count");
        bus_rd(A_CTRL, 32'h0000_0203, "norst_kick_ctrl");
        bus_wr(A_CTRL, 32'h0, e);

        // Simultaneous write and read: write lands, read returns zero
        bus_wr_rd(A_LOAD, 32'd7, "wr_rd_zero");
        bus_rd(A_LOAD, 32'd7, "wr_rd_load");
        wait_cyc(3);
        check_drained("final_edges");

        checks++;
        if (rd_q.size() != 0) begin
            errors++;
            $display("FAIL reads_drained: pending reads=%0d required 0", rd_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
